seq_detect_multi: RTL
=====================

SEQ_DETECT_MULTI -- requirements
Module: seq_detect_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent serial channels (1..16).
REQ-002 SHALL have parameter LEN, default 4, pattern length in bits (2..16).
REQ-003 SHALL have parameter PATTERN, default 4'b1011 (LEN bits), target sequence, MSB received first.
REQ-004 SHALL have parameter OVERLAP, default 1; 1 = overlapping matches allowed, 0 = fresh LEN bits required after each match.
REQ-005 SHALL have port clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  sample strobe, shared by all channels.
REQ-008 SHALL have port in_bit  input  CH  one serial bit per channel.
REQ-009 SHALL have port clear  input  1  synchronous flush of all channels.
REQ-010 SHALL have port mealy_hit  output  CH  combinational match pulse.
REQ-011 SHALL have port moore_hit  output  CH  registered match flag.
REQ-012 SHALL have port match_cnt  output  CH*16  per-channel match counters, channel c at bits [16c+15:16c].

Function
REQ-013 Per channel SHALL keep history hist (LEN-1 bits), fill count fill (0..LEN-1), and state in {S_FILL, S_ARMED, S_HIT}.
REQ-014 Accepted sample SHALL mean in_valid=1 and clear=0; hist shifts left taking in_bit[c] at LSB; fill saturates at LEN-1.
REQ-015 mealy_hit[c] SHALL equal in_valid & ~clear & (fill==LEN-1) & ({hist,in_bit[c]}==PATTERN), zero latency.
REQ-016 On an accepted sample, next state SHALL be S_HIT if mealy_hit[c], else S_ARMED if next fill==LEN-1, else S_FILL.
REQ-017 Without an accepted sample, state, hist and fill SHALL hold.
REQ-018 moore_hit[c] SHALL equal (state==S_HIT): asserted the cycle after the Mealy hit and held until the next accepted sample.
REQ-019 With OVERLAP=0, a hit SHALL reset fill and hist to 0, so the next match needs LEN new accepted samples.
REQ-020 With OVERLAP=1, a hit SHALL NOT disturb hist/fill; back-to-back hits on consecutive samples SHALL be possible if PATTERN permits.
REQ-021 clear=1 SHALL override in_valid: state S_FILL, fill 0, hist 0, counters 0 on next edge; mealy_hit forced 0 in that cycle.
REQ-022 Channels SHALL be fully independent; simultaneous hits on several channels SHALL all be reported in the same cycle.

Reset
REQ-023 reset SHALL immediately force every channel to S_FILL, fill 0, hist 0, match_cnt 0; moore_hit 0, mealy_hit 0.
REQ-024 reset asserted mid-pattern or in S_HIT SHALL discard all partial progress; after release, LEN fresh samples are needed for a hit.

Configuration
REQ-025 Macro SEQ_DETECT_MATCH_CNT_EN defined SHALL build per-channel 16-bit counters: +1 on each mealy_hit, saturating at 16'hFFFF, zeroed by reset/clear.
REQ-026 Macro SEQ_DETECT_MATCH_CNT_EN undefined SHALL tie match_cnt to all zeros; the port SHALL remain present and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package seq_detect_pkg SHALL hold the state enum typedef (S_FILL, S_ARMED, S_HIT) and constant CNT_W=16.
REQ-028 Per-channel logic SHALL be sub-module seq_detect_chan, instantiated CH times in a generate loop; the top SHALL contain only fan-out and packing.

Verification (CH=2, LEN=4, PATTERN=1011, macro defined unless noted)
REQ-029 Valid every cycle, ch0 = 1,0,1,1, ch1 = 0s -> mealy_hit=2'b01 on the 4th sample cycle, moore_hit=2'b01 the next cycle, match_cnt[0]=1, match_cnt[1]=0.
REQ-030 ch0 = 1,0,1,1,0,1,1 -> OVERLAP=1: hits at samples 4 and 7, count 2; OVERLAP=0: hit at sample 4 only, count 1.
REQ-031 ch0 = 1,0, then 3 cycles in_valid=0 with in_bit=1, then 1,1 -> a single hit on the 4th accepted sample; moore_hit held through a following 5-cycle in_valid=0 gap.
REQ-032 ch0 = 1,0,1, clear pulse, then 1 -> no hit; a full 1,0,1,1 afterwards is required for a hit; clear in a hit cycle forces mealy_hit=0 and count 0.
REQ-033 Assert reset asynchronously while moore_hit[0]=1 -> moore_hit and match_cnt drop to 0 before the next clk edge.
REQ-034 Drive 65537 overlapping hits -> match_cnt[0]=16'hFFFF with no wrap; with the macro undefined, match_cnt stays 0 throughout.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types for the multi-channel serial pattern detector.
// State encoding and match-counter width used by channel and top.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_ARMED,
        S_HIT
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/seq_detect_chan.sv
// One serial channel: history shifter, fill counter, hit FSM, match counter.
// Counter built only when SEQ_DETECT_MATCH_CNT_EN is defined.
module seq_detect_chan
    import seq_detect_pkg::*;
#(
    parameter int           LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             clear_i,
    output logic             mealy_o,
    output logic             moore_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);

    state_e         state_q, state_d;
    logic [LEN-2:0] hist_q, hist_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [LEN-1:0] shifted;
    logic           acc;
    logic           hit;

    assign acc     = valid_i & ~clear_i;
    assign shifted = {hist_q, bit_i};
    assign hit     = acc && (fill_q == FULL) && (shifted == PATTERN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (clear_i) begin
            state_d = S_FILL;
            hist_d  = '0;
            fill_d  = '0;
        end else if (acc) begin
            // Non-overlapping mode restarts the window after every match
            if (hit && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = shifted[LEN-2:0];
                fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            end
            if (hit)
                state_d = S_HIT;
            else if (fill_d == FULL)
                state_d = S_ARMED;
            else
                state_d = S_FILL;
        end
    end

    always_comb begin
        mealy_o = hit;
        moore_o = (state_q == S_HIT);
    end

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (hit && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: rtl/seq_detect_multi.sv
// CH independent pattern detectors sharing strobe and clear.
// Match counters present only with SEQ_DETECT_MATCH_CNT_EN defined.
module seq_detect_multi
    import seq_detect_pkg::*;
#(
    parameter int             CH      = 4,
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CH-1:0]       in_bit,
    input  logic                clear,
    output logic [CH-1:0]       mealy_hit,
    output logic [CH-1:0]       moore_hit,
    output logic [CH*CNT_W-1:0] match_cnt
);

    for (genvar c = 0; c < CH; c++) begin : g_chan
        seq_detect_chan #(
            .LEN     (LEN),
            .PATTERN (PATTERN),
            .OVERLAP (OVERLAP)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .valid_i (in_valid),
            .bit_i   (in_bit[c]),
            .clear_i (clear),
            .mealy_o (mealy_hit[c]),
            .moore_o (moore_hit[c]),
            .cnt_o   (match_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule
